// File: rtl/gamepad_input_scanner.sv
// SNES-style serial gamepad scanner: one latch/shift sequence per frame trigger, 12 raw bits
// decoded into a registered 10-bit button word. Optional macro ATTACK_EDGE_EN makes A/B press-edge.
module gamepad_input_scanner #(
   parameter int CLK_DIV = 150
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       trigger,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic [9:0] input_data,
   output logic       input_valid,
   output logic       pad_present
);

   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [3:0]       LAST_BIT  = 4'd11;

   typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

   state_t           state_reg;
   logic [DIV_W-1:0] div_reg;
   logic [3:0]       bit_reg;
   logic [10:0]      shift_reg;

   // Raw bit order: 0 B, 1 Y, 2 select, 3 start, 4 up, 5 down, 6 left, 7 right, 8 A, 9 X, 10 L, 11 R
   function automatic logic [9:0] map_buttons(input logic [11:0] p);
      return {p[8], p[7], p[6], p[5], p[4], p[0], p[1], p[9], p[3], p[2]};
   endfunction

   // The final sample is used directly so the decoded word lands on the edge entering DONE
   logic [11:0] raw_full;
   logic [11:0] pressed;
   logic [9:0]  level_data;
   logic        disconnected;

   assign raw_full     = {pad_data, shift_reg};
   assign pressed      = ~raw_full;
   assign level_data   = map_buttons(pressed);
   assign disconnected = (raw_full == 12'd0);

`ifdef ATTACK_EDGE_EN
   logic prev_a_reg;
   logic prev_b_reg;
   logic [9:0] decoded_data;

   always_comb begin
      decoded_data    = level_data;
      decoded_data[9] = level_data[9] & ~prev_a_reg;
      decoded_data[4] = level_data[4] & ~prev_b_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_a_reg <= 1'b0;
         prev_b_reg <= 1'b0;
      end else if (state_reg == SHIFT && div_reg == FULL_LAST && bit_reg == LAST_BIT) begin
         prev_a_reg <= disconnected ? 1'b0 : pressed[8];
         prev_b_reg <= disconnected ? 1'b0 : pressed[0];
      end
   end
`else
   logic [9:0] decoded_data;
   assign decoded_data = level_data;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         div_reg     <= '0;
         bit_reg     <= '0;
         shift_reg   <= '0;
         pad_latch   <= 1'b0;
         pad_clk     <= 1'b1;
         input_data  <= '0;
         input_valid <= 1'b0;
         pad_present <= 1'b0;
      end else begin
         input_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               pad_latch <= 1'b0;
               pad_clk   <= 1'b1;
               div_reg   <= '0;
               if (trigger) begin
                  state_reg <= LATCH;
                  pad_latch <= 1'b1;
               end
            end
            LATCH: begin
               if (div_reg == FULL_LAST) begin
                  shift_reg[0] <= pad_data;
                  pad_latch    <= 1'b0;
                  pad_clk      <= 1'b0;
                  bit_reg      <= 4'd1;
                  div_reg      <= '0;
                  state_reg    <= SHIFT;
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end
            SHIFT: begin
               if (div_reg == FULL_LAST) begin
                  div_reg <= '0;
                  if (bit_reg == LAST_BIT) begin
                     state_reg   <= DONE;
                     input_valid <= 1'b1;
                     pad_present <= ~disconnected;
                     input_data  <= disconnected ? 10'd0 : decoded_data;
                  end else begin
                     shift_reg[bit_reg] <= pad_data;
                     bit_reg            <= bit_reg + 1'b1;
                     pad_clk            <= 1'b0;
                  end
               end else begin
                  div_reg <= div_reg + 1'b1;
                  if (div_reg == HALF_LAST)
                     pad_clk <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gamepad_input_scanner.sv
// Directed bench for gamepad_input_scanner at CLK_DIV=4 with a behavioural shift-register pad.
module tb_gamepad_input_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic       trigger;
   logic       pad_data;
   logic       pad_latch;
   logic       pad_clk;
   logic [9:0] input_data;
   logic       input_valid;
   logic       pad_present;

   int errors = 0;
   int checks = 0;

   logic [11:0] btn = 12'd0;
   logic        pad_float = 1'b0;
   int          pad_bit = 0;

   always #5 clk = ~clk;

   gamepad_input_scanner #(.CLK_DIV(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .trigger    (trigger),
      .pad_data   (pad_data),
      .pad_latch  (pad_latch),
      .pad_clk    (pad_clk),
      .input_data (input_data),
      .input_valid(input_valid),
      .pad_present(pad_present)
   );

   // Pad model: latch reloads bit 0, each rising pad_clk advances to the next bit
   always @(posedge pad_latch) pad_bit = 0;
   always @(posedge pad_clk) if (!pad_latch) pad_bit = pad_bit + 1;
   assign pad_data = pad_float ? 1'b0 : ((pad_bit < 12) ? ~btn[pad_bit[3:0]] : 1'b1);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   // One scan: trigger driven at rel=0, sampled every negedge up to rel=110
   task automatic run_scan(input string name, input logic [11:0] b, input logic flt, input bit mid,
                           output logic [9:0] d, output logic pr, output int vcnt, output int vrel,
                           output int lfirst, output int llast, output int falls, output int lows);
      logic prev_clk;
      btn = b;
      pad_float = flt;
      d = 'x; pr = 'x; vcnt = 0; vrel = -1; lfirst = -1; llast = -1; falls = 0; lows = 0;
      prev_clk = 1'b1;
      @(negedge clk);
      trigger = 1'b1;
      for (int rel = 1; rel <= 110; rel++) begin
         @(negedge clk);
         trigger = (mid && rel == 39) ? 1'b1 : 1'b0;
         if (pad_latch) begin
            if (lfirst < 0) lfirst = rel;
            llast = rel;
         end
         if (!pad_clk) lows++;
         if (!pad_clk && prev_clk) falls++;
         prev_clk = pad_clk;
         if (input_valid) begin
            vcnt++;
            vrel = rel;
            d = input_data;
            pr = pad_present;
         end
      end
      $display("scan %s: data=0x%0h present=%0b valid_at=%0d", name, d, pr, vrel);
   endtask

   logic [9:0] d;
   logic       pr;
   int vcnt, vrel, lfirst, llast, falls, lows;

   initial begin
      reset = 1'b1;
      trigger = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_latch", 32'(pad_latch), 32'd0);
      chk("rst_clk", 32'(pad_clk), 32'd1);
      chk("rst_data", 32'(input_data), 32'd0);
      chk("rst_valid", 32'(input_valid), 32'd0);
      chk("rst_present", 32'(pad_present), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // A + Right
      run_scan("a_right", 12'h180, 1'b0, 1'b0, d, pr, vcnt, vrel, lfirst, llast, falls, lows);
      chk("ar_latch_first", 32'(lfirst), 32'd1);
      chk("ar_latch_last", 32'(llast), 32'd8);
      chk("ar_clk_pulses", 32'(falls), 32'd11);
      chk("ar_clk_low_cyc", 32'(lows), 32'd44);
      chk("ar_valid_cnt", 32'(vcnt), 32'd1);
      chk("ar_valid_at", 32'(vrel), 32'd97);
      chk("ar_data", 32'(d), 32'h300);
      chk("ar_present", 32'(pr), 32'd1);

      // Floating pad: all zeros
      run_scan("float", 12'h000, 1'b1, 1'b0, d, pr, vcnt, vrel, lfirst, llast, falls, lows);
      chk("fl_valid_at", 32'(vrel), 32'd97);
      chk("fl_data", 32'(d), 32'h000);
      chk("fl_present", 32'(pr), 32'd0);

      // Up + Down + B with a second trigger mid-scan
      run_scan("ud_b_mid", 12'h031, 1'b0, 1'b1, d, pr, vcnt, vrel, lfirst, llast, falls, lows);
      chk("mid_valid_cnt", 32'(vcnt), 32'd1);
      chk("mid_valid_at", 32'(vrel), 32'd97);
      chk("mid_clk_pulses", 32'(falls), 32'd11);
      chk("udb_data", 32'(d), 32'h070);
      chk("udb_present", 32'(pr), 32'd1);
      repeat (20) @(negedge clk);
      chk("hold_data", 32'(input_data), 32'h070);

      // Y, X, start, select plus discarded L and R
      run_scan("yx_ss_lr", 12'hE0E, 1'b0, 1'b0, d, pr, vcnt, vrel, lfirst, llast, falls, lows);
      chk("yxss_data", 32'(d), 32'h00F);

      // A held over three scans, released, pressed again
      run_scan("a_hold1", 12'h100, 1'b0, 1'b0, d, pr, vcnt, vrel, lfirst, llast, falls, lows);
      chk("a_hold1", 32'(d[9]), 32'd1);
      run_scan("a_hold2", 12'h100, 1'b0, 1'b0, d, pr, vcnt, vrel, lfirst, llast, falls, lows);
`ifdef ATTACK_EDGE_EN
      chk("a_hold2", 32'(d[9]), 32'd0);
`else
      chk("a_hold2", 32'(d[9]), 32'd1);
`endif
      run_scan("a_hold3", 12'h100, 1'b0, 1'b0, d, pr, vcnt, vrel, lfirst, llast, falls, lows);
`ifdef ATTACK_EDGE_EN
      chk("a_hold3", 32'(d[9]), 32'd0);
`else
      chk("a_hold3", 32'(d[9]), 32'd1);
`endif
      run_scan("a_release", 12'h000, 1'b0, 1'b0, d, pr, vcnt, vrel, lfirst, llast, falls, lows);
      chk("a_release", 32'(d), 32'h000);
      chk("a_release_present", 32'(pr), 32'd1);
      run_scan("a_repress", 12'h100, 1'b0, 1'b0, d, pr, vcnt, vrel, lfirst, llast, falls, lows);
      chk("a_repress", 32'(d), 32'h200);

      // Reset in the middle of SHIFT
      btn = 12'h180;
      pad_float = 1'b0;
      @(negedge clk);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      repeat (49) @(negedge clk);
      chk("pre_rst_data", 32'(input_data), 32'h200);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_latch", 32'(pad_latch), 32'd0);
      chk("mid_rst_clk", 32'(pad_clk), 32'd1);
      chk("mid_rst_data", 32'(input_data), 32'd0);
      chk("mid_rst_valid", 32'(input_valid), 32'd0);
      vcnt = 0;
      falls = 0;
      for (int i = 0; i < 110; i++) begin
         @(negedge clk);
         if (input_valid) vcnt++;
         if (!pad_clk || pad_latch) falls++;
      end
      chk("post_rst_no_valid", 32'(vcnt), 32'd0);
      chk("post_rst_idle_pins", 32'(falls), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
